// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared Wishbone widths and arbiter state type
package wb_arbiter_pkg;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  typedef enum logic {IDLE, OWNED} state_e;
endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// rr_picker: round-robin one-hot picker starting after ptr and wrapping
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int j = N - 1; j >= 0; j--)
      if (req[j] && j <= int'(ptr)) idx = IW'(j);
    for (int j = N - 1; j >= 0; j--)
      if (req[j] && j > int'(ptr)) idx = IW'(j);
  end
  assign gnt = (|req) ? N'(1) << idx : '0;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone bus arbiter with locked cycles and strobe timeout
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS-1:0][ADR_W-1:0]   m_adr_i,
  input  logic [NUM_MASTERS-1:0][DAT_W-1:0]   m_dat_i,
  input  logic [NUM_MASTERS-1:0][SEL_W-1:0]   m_sel_i,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic [DAT_W-1:0]                    m_dat_o,
  output logic                                cyc_o,
  output logic                                stb_o,
  output logic                                we_o,
  output logic [ADR_W-1:0]                    adr_o,
  output logic [DAT_W-1:0]                    dat_o,
  output logic [SEL_W-1:0]                    sel_o,
  input  logic                                ack_i,
  input  logic                                err_i,
  input  logic [DAT_W-1:0]                    dat_i,
  output logic [NUM_MASTERS-1:0]              grant_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e                 state;
  logic [NUM_MASTERS-1:0] grant, pick;
  logic [IW-1:0]          own, ptr, pick_idx;
  logic [CW-1:0]          cnt;
  logic                   owned, stb_raw, to, ack, err;
  rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req (m_cyc_i),
    .ptr (ptr),
    .gnt (pick),
    .idx (pick_idx)
  );
  assign owned   = state == OWNED;
  assign cyc_o   = owned & m_cyc_i[own];
  assign stb_raw = cyc_o & m_stb_i[own];
  assign to      = stb_raw & (cnt == CW'(TIMEOUT));
  assign stb_o   = stb_raw & ~to;
  assign we_o    = cyc_o & m_we_i[own];
  assign adr_o   = owned ? m_adr_i[own] : '0;
  assign dat_o   = owned ? m_dat_i[own] : '0;
  assign sel_o   = owned ? m_sel_i[own] : '0;
  assign m_dat_o = owned ? dat_i : '0;
  assign err     = owned & (err_i | to);
  assign ack     = owned & ack_i & ~err;
  assign m_ack_o = NUM_MASTERS'(ack) << own;
  assign m_err_o = NUM_MASTERS'(err) << own;
  assign grant_o = grant;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      grant <= '0;
      own   <= '0;
      ptr   <= IW'(NUM_MASTERS - 1);
      cnt   <= '0;
    end else begin
      cnt <= (stb_o && !ack_i && !err_i) ? cnt + CW'(cnt != CW'(TIMEOUT)) : '0;
      if (state == IDLE && |m_cyc_i) begin
        state <= OWNED;
        grant <= pick;
        own   <= pick_idx;
      end else if (state == OWNED && !m_cyc_i[own]) begin
        state <= IDLE;
        grant <= '0;
        ptr   <= own;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (2 masters, TIMEOUT=8)
module tb_wb_arbiter;
  localparam int N = 2;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, grant_o;
  logic [N-1:0][31:0] m_adr_i, m_dat_i;
  logic [N-1:0][3:0] m_sel_i;
  logic [31:0] m_dat_o, adr_o, dat_o, dat_i;
  logic [3:0] sel_o;
  logic cyc_o, stb_o, we_o, ack_i, err_i;
  int errs = 0;
  int checks = 0;
  wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .grant_o(grant_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask
  initial begin
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    m_we_i = 2'b01;
    m_adr_i[0] = 32'h1000_0000;
    m_adr_i[1] = 32'h2000_0004;
    m_dat_i[0] = 32'h1111_1111;
    m_dat_i[1] = 32'h2222_2222;
    m_sel_i[0] = 4'hf;
    m_sel_i[1] = 4'h3;
    ack_i = 1'b1;
    err_i = 1'b1;
    dat_i = 32'hDEAD_BEEF;
    #12;
    chk("rst_grant", grant_o, 0);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_mdat", m_dat_o, 0);
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("cont_m0_grant", grant_o, 2'b01);
    chk("cont_cyc", cyc_o, 1);
    chk("cont_stb", stb_o, 1);
    chk("cont_adr", adr_o, 32'h1000_0000);
    chk("cont_dat", dat_o, 32'h1111_1111);
    chk("cont_sel", sel_o, 4'hf);
    chk("cont_we", we_o, 1);
    m_cyc_i = 2'b10;
    #1;
    chk("rel_cyc_gated", cyc_o, 0);
    chk("rel_stb_gated", stb_o, 0);
    chk("rel_grant_held", grant_o, 2'b01);
    tick();
    chk("gap_idle", grant_o, 2'b00);
    tick();
    chk("cont_m1_grant", grant_o, 2'b10);
    chk("cont_m1_adr", adr_o, 32'h2000_0004);
    chk("cont_m1_we", we_o, 0);
    m_cyc_i = 2'b11;
    ack_i = 1'b1;
    dat_i = 32'hDEAD_BEEF;
    #1;
    chk("rd_ack", m_ack_o, 2'b10);
    chk("rd_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("rd_noerr", m_err_o, 2'b00);
    err_i = 1'b1;
    #1;
    chk("both_err", m_err_o, 2'b10);
    chk("both_noack", m_ack_o, 2'b00);
    ack_i = 1'b0;
    err_i = 1'b0;
    m_cyc_i = 2'b01;
    tick();
    chk("m1_rel_idle", grant_o, 2'b00);
    tick();
    chk("m0_regrant", grant_o, 2'b01);
    m_cyc_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ack_i = 1'b1;
      #1;
      chk("lock_ack_m0only", m_ack_o, 2'b01);
      tick();
      chk("lock_grant", grant_o, 2'b01);
    end
    ack_i = 1'b0;
    m_cyc_i = 2'b10;
    tick();
    chk("lock_rel_idle", grant_o, 2'b00);
    tick();
    chk("lock_m1_grant", grant_o, 2'b10);
    m_cyc_i = 2'b11;
    tick();
    m_cyc_i = 2'b10;
    tick();
    m_cyc_i = 2'b00;
    tick();
    chk("drop_idle", grant_o, 2'b00);
    tick();
    chk("drop_ignored", grant_o, 2'b00);
    m_stb_i = 2'b00;
    m_cyc_i = 2'b10;
    tick();
    chk("to_grant", grant_o, 2'b10);
    m_stb_i = 2'b10;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("to_wait_stb", stb_o, 1);
      chk("to_wait_err", m_err_o, 2'b00);
      tick();
    end
    chk("to_err", m_err_o, 2'b10);
    chk("to_stb_low", stb_o, 0);
    chk("to_noack", m_ack_o, 2'b00);
    tick();
    chk("to_restart_err", m_err_o, 2'b00);
    chk("to_restart_stb", stb_o, 1);
    ack_i = 1'b1;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_cyc", cyc_o, 0);
    chk("midrst_grant", grant_o, 2'b00);
    chk("midrst_ack", m_ack_o, 2'b00);
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    ack_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_grant", grant_o, 2'b00);
    chk("post_rst_ack", m_ack_o, 2'b00);
    chk("post_rst_err", m_err_o, 2'b00);
    m_cyc_i = 2'b10;
    m_stb_i = 2'b10;
    tick();
    chk("post_rst_m1", grant_o, 2'b01 << 1);
    chk("post_rst_noack", m_ack_o, 2'b00);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
